// File: rtl/imem_loader.sv
// imem_loader -- serial boot loader for an instruction memory.
//
// Receives a byte stream framed as: 0x55, count N, 4*N data bytes (each word
// big-endian), and an optional trailing checksum byte. Each assembled word is
// written to the instruction memory with a one-cycle write strobe, and the CPU
// is held in reset while a frame is in progress.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : an 8-bit modulo-256 sum of the data bytes is kept and the byte
//               after the last word must match it (CHECK state present).
//   undefined : no checksum; the frame completes with the last word write.
//
// Parameters
//   ROM_SIZE_BIT   : word-index bits (capacity 2^ROM_SIZE_BIT words)
//   TIMEOUT_CYCLES : idle cycles allowed between bytes of a frame
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   rx_valid   in   one-cycle strobe marking a received byte
//   rx_data    in   [7:0] received byte
//   mem_we     out  instruction-memory write strobe (one cycle per word)
//   mem_addr   out  [31:0] byte address, word index in [ROM_SIZE_BIT+1:2]
//   mem_wdata  out  [31:0] instruction word
//   cpu_hold   out  1 while a frame is in progress
//   done       out  sticky: last frame completed
//   error      out  sticky: last frame aborted (timeout or bad checksum)
//
// Handshake: rx_valid has no back-pressure; a byte is consumed in every cycle
// rx_valid is 1, including cycles in which mem_we is asserted. The FSM state
// is held in the internal signal 'state' for hierarchical probing.

module imem_loader #(
  parameter int ROM_SIZE_BIT   = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, COUNT, DATA, CHECK, DONE, ERR} state_t;
`else
  typedef enum logic [2:0] {IDLE, COUNT, DATA, DONE, ERR} state_t;
`endif

  state_t                  state;
  state_t                  state_next;
  logic [ROM_SIZE_BIT-1:0] idx;
  logic [ROM_SIZE_BIT-1:0] last_idx;
  logic [1:0]              lane;
  logic [23:0]             asm_q;
  logic [31:0]             timer;
  logic                    busy;
  logic                    busy_next;
  logic                    count_take;
  logic                    data_take;
  logic                    timeout_hit;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              sum;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    busy        = 1'b0;
    busy_next   = 1'b0;
    count_take  = 1'b0;
    data_take   = 1'b0;
    timeout_hit = 1'b0;

    busy = (state == COUNT) || (state == DATA)
`ifdef LOADER_CHECKSUM_EN
           || (state == CHECK)
`endif
           ;
    count_take = (state == COUNT) && rx_valid;
    data_take  = (state == DATA) && rx_valid;
    // The timer holds the number of idle cycles already seen; the edge that
    // would make it reach TIMEOUT_CYCLES aborts the frame instead.
    timeout_hit = busy && !rx_valid && (timer == 32'(TIMEOUT_CYCLES - 1));

    case (state)
      IDLE, DONE, ERR: if (rx_valid && rx_data == 8'h55) state_next = COUNT;
      COUNT:           if (rx_valid) state_next = DATA;
      DATA: begin
        if (data_take && lane == 2'd3 && idx == last_idx) begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: if (rx_valid) state_next = (rx_data == sum) ? DONE : ERR;
`endif
      default:         state_next = IDLE;
    endcase

    if (timeout_hit) state_next = ERR;

    busy_next = (state_next == COUNT) || (state_next == DATA)
`ifdef LOADER_CHECKSUM_EN
                || (state_next == CHECK)
`endif
                ;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_hold  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      idx       <= '0;
      last_idx  <= '0;
      lane      <= '0;
      asm_q     <= '0;
      timer     <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      mem_we   <= 1'b0;
      cpu_hold <= busy_next;
      // done/error are sticky because DONE/ERR persist until the next sync.
      done     <= (state_next == DONE);
      error    <= (state_next == ERR);
      timer    <= (!busy || rx_valid) ? '0 : timer + 32'd1;

      if (count_take) begin
        // Subtracting 1 in the index width makes N=0 select the full capacity.
        last_idx <= ROM_SIZE_BIT'(rx_data) - ROM_SIZE_BIT'(1);
        idx      <= '0;
        lane     <= '0;
`ifdef LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end

      if (data_take) begin
        asm_q <= {asm_q[15:0], rx_data};
        lane  <= lane + 2'd1;
`ifdef LOADER_CHECKSUM_EN
        sum   <= sum + rx_data;
`endif
        if (lane == 2'd3) begin
          mem_we    <= 1'b1;
          mem_addr  <= 32'({idx, 2'b00});
          mem_wdata <= {asm_q, rx_data};
          // The last word leaves the FSM, so the index never wraps.
          if (idx != last_idx) idx <= idx + ROM_SIZE_BIT'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader (ROM_SIZE_BIT=8, TIMEOUT_CYCLES=16).
// Writes seen on mem_we are captured at the falling edge and compared against
// an expected queue of {addr, wdata} built from hand-computed frames.

module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_q[$];
  logic [63:0] cap_q[$];

  imem_loader #(
    .ROM_SIZE_BIT  (8),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // write capture
  always @(negedge clk) begin
    if (mem_we === 1'b1) cap_q.push_back({mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [63:0] e;
    logic [63:0] c;
    check({tag, "_count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && cap_q.size() > 0) begin
      e = exp_q.pop_front();
      c = cap_q.pop_front();
      check({tag, "_addr"}, c[63:32], e[63:32]);
      check({tag, "_data"}, c[31:0], e[31:0]);
    end
    exp_q.delete();
    cap_q.delete();
  endtask

  // driver tasks
  task automatic do_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  w8;
    logic [7:0]  cs;
    logic [31:0] word;

    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reset    = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // reset state
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);

    // a non-sync byte in IDLE is ignored
    send_byte(8'hA3);
    check("idle_ignore_hold", 32'(cpu_hold), 32'd0);

    // single-word frame 55 01 20 08 00 05 [2D]
    send_byte(8'h55);
    check("f1_hold_count", 32'(cpu_hold), 32'd1);
    send_byte(8'h01);
    check("f1_hold_data", 32'(cpu_hold), 32'd1);
    send_byte(8'h20);
    send_byte(8'h08);
    send_byte(8'h00);
    check("f1_no_early_we", 32'(mem_we), 32'd0);
    send_byte(8'h05);
    check("f1_we", 32'(mem_we), 32'd1);
    check("f1_addr", mem_addr, 32'h0000_0000);
    check("f1_wdata", mem_wdata, 32'h2008_0005);
`ifdef LOADER_CHECKSUM_EN
    check("f1_hold_check", 32'(cpu_hold), 32'd1);
    send_byte(8'h2D);
`endif
    idle(1);
    check("f1_we_one_cycle", 32'(mem_we), 32'd0);
    check("f1_done", 32'(done), 32'd1);
    check("f1_error", 32'(error), 32'd0);
    check("f1_hold_end", 32'(cpu_hold), 32'd0);
    exp_q.push_back({32'h0, 32'h2008_0005});
    check_writes("f1");

    // three-word frame, back-to-back bytes
    send_byte(8'h55);
    check("f2_done_cleared", 32'(done), 32'd0);
    send_byte(8'h03);
    send_word(32'h1111_1111);
    send_word(32'h2222_2222);
    send_word(32'h3333_3333);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h98);
`endif
    idle(2);
    check("f2_done", 32'(done), 32'd1);
    check("f2_hold", 32'(cpu_hold), 32'd0);
    exp_q.push_back({32'h0, 32'h1111_1111});
    exp_q.push_back({32'h4, 32'h2222_2222});
    exp_q.push_back({32'h8, 32'h3333_3333});
    check_writes("f2");

    // 0x55 inside a frame is data, not resync
    send_byte(8'h55);
    send_byte(8'h01);
    send_word(32'h55AA_5500);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h54);
`endif
    idle(2);
    check("f3_done", 32'(done), 32'd1);
    exp_q.push_back({32'h0, 32'h55AA_5500});
    check_writes("f3");

`ifdef LOADER_CHECKSUM_EN
    // wrong checksum: word still written, frame ends in error
    send_byte(8'h55);
    send_byte(8'h01);
    send_word(32'h0102_0304);
    send_byte(8'h0B);
    idle(2);
    check("cs_error", 32'(error), 32'd1);
    check("cs_done", 32'(done), 32'd0);
    check("cs_hold", 32'(cpu_hold), 32'd0);
    exp_q.push_back({32'h0, 32'h0102_0304});
    check_writes("cs");
`endif

    // timeout after two data bytes: error on the 16th cycle after the last byte
    send_byte(8'h55);
    send_byte(8'h02);
    send_byte(8'hDE);
    send_byte(8'hAD);
    idle(15);
    check("to_error_c15", 32'(error), 32'd0);
    check("to_hold_c15", 32'(cpu_hold), 32'd1);
    idle(1);
    check("to_error_c16", 32'(error), 32'd1);
    check("to_hold_c16", 32'(cpu_hold), 32'd0);
    check("to_done", 32'(done), 32'd0);
    check_writes("to");

    // reset mid-frame after 5 data bytes, with a same-cycle sync byte
    send_byte(8'h55);
    check("rs_error_cleared", 32'(error), 32'd0);
    send_byte(8'h02);
    send_word(32'h0BAD_F00D);
    send_byte(8'h77);
    exp_q.push_back({32'h0, 32'h0BAD_F00D});
    check_writes("rs_pre");
    reset    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    check("rs_hold", 32'(cpu_hold), 32'd0);
    check("rs_done", 32'(done), 32'd0);
    check("rs_addr", mem_addr, 32'd0);
    send_byte(8'h55);
    send_byte(8'h01);
    send_word(32'hCAFE_BABE);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h40);
`endif
    idle(2);
    check("rs_done_fresh", 32'(done), 32'd1);
    exp_q.push_back({32'h0, 32'hCAFE_BABE});
    check_writes("rs");

    // count 00 -> 256 words, 1024 back-to-back bytes
    cs = 8'h00;
    send_byte(8'h55);
    send_byte(8'h00);
    for (int w = 0; w < 256; w++) begin
      w8   = 8'(w);
      word = {w8, w8 ^ 8'h5A, ~w8, w8 + 8'd7};
      send_word(word);
      cs = cs + word[31:24] + word[23:16] + word[15:8] + word[7:0];
      exp_q.push_back({32'(w * 4), word});
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`endif
    idle(2);
    check("full_done", 32'(done), 32'd1);
    check("full_last_addr", mem_addr, 32'h0000_03FC);
    check_writes("full");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The block SHALL have the parameter ROM_SIZE_BIT, default 8, giving the number of word-index bits (capacity 2^ROM_SIZE_BIT words).
REQ-002 The block SHALL have the parameter TIMEOUT_CYCLES, default 1000000, giving the idle cycles allowed between bytes of a frame before abort.
REQ-003 The block SHALL have the port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have the port rx_valid, input, 1 bit: one-cycle strobe marking a received byte.
REQ-006 The block SHALL have the port rx_data, input, 8 bits: the received byte, valid while rx_valid=1.
REQ-007 The block SHALL have the port mem_we, output, 1 bit: instruction-memory write strobe.
REQ-008 The block SHALL have the port mem_addr, output, 32 bits: byte address of the write; word index in bits [ROM_SIZE_BIT+1:2], all other bits 0.
REQ-009 The block SHALL have the port mem_wdata, output, 32 bits: the instruction word to write.
REQ-010 The block SHALL have the port cpu_hold, output, 1 bit: holds the CPU in reset while a frame is in progress.
REQ-011 The block SHALL have the ports done and error, outputs, 1 bit each: sticky status of the last frame.

Function
REQ-012 Frame format SHALL be: sync byte 0x55, count byte N (0 encodes 2^ROM_SIZE_BIT when ROM_SIZE_BIT=8, otherwise N taken modulo capacity with 0 meaning capacity), then 4*N data bytes with each word big-endian (first byte -> bits 31:24), then the optional checksum byte (REQ-024).
REQ-013 The FSM states SHALL be IDLE, COUNT, DATA, CHECK, DONE and ERR; each transition consumes exactly one byte, except timeout.
REQ-014 In IDLE, DONE or ERR, a byte 0x55 SHALL go to COUNT and clear done and error; any other byte SHALL be ignored.
REQ-015 COUNT SHALL latch N, reset the word index to 0 and the byte lane to 0, then go to DATA.
REQ-016 DATA SHALL shift each byte into a 32-bit assembly register; on the 4th byte of a word, mem_we SHALL be 1 on the next cycle for exactly one cycle, with mem_addr = index<<2 and mem_wdata = the assembled word.
REQ-017 After the write of word N-1, the FSM SHALL go to CHECK (checksum enabled) or DONE (disabled); the word index SHALL never exceed capacity-1 and never wrap within a frame.
REQ-018 cpu_hold SHALL be 1 in COUNT, DATA and CHECK, and 0 in IDLE, DONE and ERR.
REQ-019 The timeout counter SHALL clear on every accepted byte; if it reaches TIMEOUT_CYCLES in COUNT, DATA or CHECK, the FSM SHALL go to ERR and set error=1; writes already issued SHALL not be retracted.
REQ-020 A 0x55 byte received in COUNT, DATA or CHECK SHALL be treated as data, not as resync.
REQ-021 rx_valid arriving in the same cycle as mem_we SHALL be accepted without loss.

Reset
REQ-022 On reset=1 at a clock edge, the block SHALL enter IDLE with mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, done=0, error=0, index, lane, checksum and timeout all 0; reset mid-frame SHALL abandon the frame with no further writes.
REQ-023 Reset SHALL take priority over rx_valid in the same cycle.

Configuration
REQ-024 With LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all data bytes; in CHECK the received byte SHALL be compared with it, going to DONE (done=1) on a match and to ERR (error=1) on a mismatch.
REQ-025 Without LOADER_CHECKSUM_EN, the CHECK state and the sum logic SHALL be absent, and DONE (done=1) SHALL follow the last write directly.

Verification
REQ-026 Scenario: bytes 55 01 20 08 00 05 [cs 2D] -> one mem_we with addr 0x0, wdata 0x20080005; done=1; cpu_hold 1 from the count byte to the end.
REQ-027 Scenario: N=3 frame with words 0x11111111, 0x22222222, 0x33333333 -> writes at 0x0, 0x4 and 0x8 in order; done=1.
REQ-028 Scenario: frame with a wrong checksum byte (EN build) -> all words written, error=1, done=0, cpu_hold=0.
REQ-029 Scenario: TIMEOUT_CYCLES=16 and the stream stops after 2 data bytes -> error=1 on cycle 16 after the last byte, and no mem_we.
REQ-030 Scenario: reset pulsed after 5 data bytes, then a fresh N=1 frame -> only the fresh word is written at 0x0, and done=1.
REQ-031 Scenario: count byte 00 with 1024 data bytes -> 256 writes, last at 0x3FC, with rx_valid back-to-back every cycle and no byte lost.
